// File: rtl/usb_bulk_router.sv
// usb_bulk_router
//   Routes the protocol core's single bulk data path to NUM_EPS AXI4-Stream
//   endpoint channels. The token endpoint number is decoded into a channel
//   index, that channel's readiness is reported back to the core, and the IN
//   and OUT streams are steered to it. IN packets longer than MAX_PACKET are
//   cut with a forced tlast. OUT packets that saw a core error are tagged on
//   their last beat. A dropped transfer or a USB bus reset aborts the channel.
//
// Ports
//   clock, areset_n          clock, asynchronous active-low reset
//   usb_reset_i              USB bus reset, aborts any transfer
//   blk_*_i / blk_*_o        token/transfer control from and to the core
//   c_t*_o / c_tready_i      IN stream toward the core
//   c_t*_i / c_tready_o      OUT stream from the core
//   ep_in_ready_i            per-channel IN packet available
//   ep_out_ready_i           per-channel OUT space available
//   s_t*_i / s_tready_o      per-channel IN streams from the user FIFOs
//   m_t*_o / m_tready_i      per-channel OUT streams to the user FIFOs
//   ep_active_o              one-hot selected channel
//   ep_abort_o               one-cycle abort pulse on the selected channel
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_IDLE     | no transfer; waiting for blk_start_i
// ST_IN_XFER  | selected channel streams to the core
// ST_OUT_XFER | core streams to the selected channel
module usb_bulk_router #(
    parameter int NUM_EPS    = 2,
    parameter int EP_FIRST   = 1,
    parameter int MAX_PACKET = 512
) (
    input  logic                   clock,
    input  logic                   areset_n,
    input  logic                   usb_reset_i,
    input  logic [3:0]             blk_endpt_i,
    input  logic                   blk_dir_i,
    input  logic                   blk_start_i,
    input  logic                   blk_cycle_i,
    input  logic                   blk_error_i,
    output logic                   blk_in_ready_o,
    output logic                   blk_out_ready_o,
    output logic                   blk_error_o,
    output logic                   c_tvalid_o,
    input  logic                   c_tready_i,
    output logic                   c_tlast_o,
    output logic [7:0]             c_tdata_o,
    input  logic                   c_tvalid_i,
    output logic                   c_tready_o,
    input  logic                   c_tlast_i,
    input  logic [7:0]             c_tdata_i,
    input  logic [NUM_EPS-1:0]     ep_in_ready_i,
    input  logic [NUM_EPS-1:0]     ep_out_ready_i,
    input  logic [NUM_EPS-1:0]     s_tvalid_i,
    input  logic [NUM_EPS-1:0]     s_tlast_i,
    output logic [NUM_EPS-1:0]     s_tready_o,
    input  logic [8*NUM_EPS-1:0]   s_tdata_i,
    output logic [NUM_EPS-1:0]     m_tvalid_o,
    output logic [NUM_EPS-1:0]     m_tlast_o,
    output logic [NUM_EPS-1:0]     m_terr_o,
    input  logic [NUM_EPS-1:0]     m_tready_i,
    output logic [8*NUM_EPS-1:0]   m_tdata_o,
    output logic [NUM_EPS-1:0]     ep_active_o,
    output logic [NUM_EPS-1:0]     ep_abort_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IN_XFER  = 2'd1,
        ST_OUT_XFER = 2'd2
    } state_t;

    localparam logic [3:0] EP_FIRST_L = 4'(EP_FIRST);
    localparam logic [4:0] NUM_EPS_L  = 5'(NUM_EPS);
    localparam logic [9:0] LAST_CNT   = 10'(MAX_PACKET - 1);

    state_t     state_q, state_d;
    logic [3:0] sel_q, sel_d;
    logic [9:0] count_q, count_d;
    logic       err_seen_q, err_seen_d;
    logic       blk_in_ready_q, blk_in_ready_d;
    logic       blk_out_ready_q, blk_out_ready_d;
    logic       blk_error_q, blk_error_d;

    logic [3:0]         idx;
    logic               hit;
    logic               in_rdy_at, out_rdy_at;
    logic [NUM_EPS-1:0] sel_onehot;
    logic               sel_valid, sel_last, sel_mready;
    logic [7:0]         sel_data;
    logic               in_xfer, out_xfer, abort;
    logic               in_hs, out_hs;

    // Endpoint decode and per-channel muxing. Loops compare against the
    // index instead of indexing directly so out-of-range endpoints read 0.
    always_comb begin
        idx        = blk_endpt_i - EP_FIRST_L;
        hit        = (blk_endpt_i >= EP_FIRST_L) && ({1'b0, idx} < NUM_EPS_L);
        in_rdy_at  = 1'b0;
        out_rdy_at = 1'b0;
        sel_onehot = '0;
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_mready = 1'b0;
        sel_data   = 8'd0;
        for (int k = 0; k < NUM_EPS; k++) begin
            if (idx == 4'(k)) begin
                in_rdy_at  = ep_in_ready_i[k];
                out_rdy_at = ep_out_ready_i[k];
            end
            if (sel_q == 4'(k)) begin
                sel_onehot[k] = 1'b1;
                sel_valid     = s_tvalid_i[k];
                sel_last      = s_tlast_i[k];
                sel_mready    = m_tready_i[k];
                sel_data      = s_tdata_i[8*k +: 8];
            end
        end
    end

    // Data path. In the abort cycle every handshake qualifier is forced low
    // so no beat can move while the channel is being torn down.
    always_comb begin
        in_xfer  = (state_q == ST_IN_XFER);
        out_xfer = (state_q == ST_OUT_XFER);
        abort    = (in_xfer || out_xfer) && (!blk_cycle_i || usb_reset_i);

        c_tvalid_o  = in_xfer && !abort && sel_valid;
        c_tdata_o   = in_xfer ? sel_data : 8'd0;
        c_tlast_o   = in_xfer && (sel_last || (count_q == LAST_CNT));
        s_tready_o  = (in_xfer && !abort && c_tready_i) ? sel_onehot : '0;

        c_tready_o  = out_xfer && !abort && sel_mready;
        m_tvalid_o  = (out_xfer && !abort && c_tvalid_i) ? sel_onehot : '0;
        m_tlast_o   = (out_xfer && c_tlast_i) ? sel_onehot : '0;
        m_terr_o    = m_tvalid_o & {NUM_EPS{(err_seen_q || blk_error_i) && c_tlast_i}};
        m_tdata_o   = '0;
        for (int k = 0; k < NUM_EPS; k++) begin
            if (out_xfer && sel_onehot[k]) begin
                m_tdata_o[8*k +: 8] = c_tdata_i;
            end
        end

        ep_active_o = (in_xfer || out_xfer) ? sel_onehot : '0;
        ep_abort_o  = abort ? sel_onehot : '0;

        in_hs  = c_tvalid_o && c_tready_i;
        out_hs = c_tvalid_i && c_tready_o;
    end

    // Next-state logic.
    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
        count_d         = count_q;
        err_seen_d      = err_seen_q;
        blk_error_d     = 1'b0;
        blk_in_ready_d  = hit && in_rdy_at;
        blk_out_ready_d = hit && out_rdy_at;

        case (state_q)
            ST_IDLE: begin
                if (blk_start_i && !usb_reset_i) begin
                    if (!hit) begin
                        blk_error_d = 1'b1;
                    end else begin
                        sel_d      = idx;
                        count_d    = 10'd0;
                        err_seen_d = 1'b0;
                        state_d    = blk_dir_i ? ST_IN_XFER : ST_OUT_XFER;
                    end
                end
            end
            ST_IN_XFER: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (in_hs) begin
                    if (c_tlast_o) begin
                        count_d = 10'd0;
                        state_d = ST_IDLE;
                    end else begin
                        count_d = count_q + 10'd1;
                    end
                end
            end
            ST_OUT_XFER: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (blk_error_i) begin
                        err_seen_d = 1'b1;
                    end
                    if (out_hs && c_tlast_i) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            state_q         <= ST_IDLE;
            sel_q           <= 4'd0;
            count_q         <= 10'd0;
            err_seen_q      <= 1'b0;
            blk_in_ready_q  <= 1'b0;
            blk_out_ready_q <= 1'b0;
            blk_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            sel_q           <= sel_d;
            count_q         <= count_d;
            err_seen_q      <= err_seen_d;
            blk_in_ready_q  <= blk_in_ready_d;
            blk_out_ready_q <= blk_out_ready_d;
            blk_error_q     <= blk_error_d;
        end
    end

    assign blk_in_ready_o  = blk_in_ready_q;
    assign blk_out_ready_o = blk_out_ready_q;
    assign blk_error_o     = blk_error_q;

endmodule

// File: tb/tb_usb_bulk_router.sv
// Directed bench for usb_bulk_router with NUM_EPS=2, EP_FIRST=1, MAX_PACKET=8.
// Inputs change on the falling edge; outputs are checked just after, away
// from the rising edge the design samples on.
module tb_usb_bulk_router;

    localparam int NEPS = 2;
    localparam int MAXP = 8;

    logic        clock = 1'b0;
    logic        areset_n;
    logic        usb_reset_i;
    logic [3:0]  blk_endpt_i;
    logic        blk_dir_i, blk_start_i, blk_cycle_i, blk_error_i;
    logic        blk_in_ready_o, blk_out_ready_o, blk_error_o;
    logic        c_tvalid_o, c_tready_i, c_tlast_o;
    logic [7:0]  c_tdata_o;
    logic        c_tvalid_i, c_tready_o, c_tlast_i;
    logic [7:0]  c_tdata_i;
    logic [NEPS-1:0]   ep_in_ready_i, ep_out_ready_i;
    logic [NEPS-1:0]   s_tvalid_i, s_tlast_i, s_tready_o;
    logic [8*NEPS-1:0] s_tdata_i;
    logic [NEPS-1:0]   m_tvalid_o, m_tlast_o, m_terr_o, m_tready_i;
    logic [8*NEPS-1:0] m_tdata_o;
    logic [NEPS-1:0]   ep_active_o, ep_abort_o;

    int tests = 0;
    int fails = 0;
    int src_ptr;

    usb_bulk_router #(.NUM_EPS(NEPS), .EP_FIRST(1), .MAX_PACKET(MAXP)) dut (
        .clock(clock), .areset_n(areset_n), .usb_reset_i(usb_reset_i),
        .blk_endpt_i(blk_endpt_i), .blk_dir_i(blk_dir_i), .blk_start_i(blk_start_i),
        .blk_cycle_i(blk_cycle_i), .blk_error_i(blk_error_i),
        .blk_in_ready_o(blk_in_ready_o), .blk_out_ready_o(blk_out_ready_o),
        .blk_error_o(blk_error_o),
        .c_tvalid_o(c_tvalid_o), .c_tready_i(c_tready_i), .c_tlast_o(c_tlast_o),
        .c_tdata_o(c_tdata_o),
        .c_tvalid_i(c_tvalid_i), .c_tready_o(c_tready_o), .c_tlast_i(c_tlast_i),
        .c_tdata_i(c_tdata_i),
        .ep_in_ready_i(ep_in_ready_i), .ep_out_ready_i(ep_out_ready_i),
        .s_tvalid_i(s_tvalid_i), .s_tlast_i(s_tlast_i), .s_tready_o(s_tready_o),
        .s_tdata_i(s_tdata_i),
        .m_tvalid_o(m_tvalid_o), .m_tlast_o(m_tlast_o), .m_terr_o(m_terr_o),
        .m_tready_i(m_tready_i), .m_tdata_o(m_tdata_o),
        .ep_active_o(ep_active_o), .ep_abort_o(ep_abort_o)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_src();
        s_tvalid_i = '0;
        s_tlast_i  = '0;
        s_tdata_i  = '0;
        c_tready_i = 1'b0;
    endtask

    // Caller sits on a falling edge; returns one falling edge later.
    task automatic start_xfer(input logic [3:0] ep, input logic dir, input int ch);
        blk_endpt_i = ep;
        blk_dir_i   = dir;
        blk_start_i = 1'b1;
        blk_cycle_i = 1'b1;
        @(negedge clock);
        blk_start_i = 1'b0;
        check("start_active", 32'(ep_active_o), 1 << ch);
    endtask

    task automatic drive_src(input int ch, input int ulen, input logic [7:0] base);
        clear_src();
        s_tvalid_i[ch]         = 1'b1;
        s_tdata_i[ch*8 +: 8]   = base + 8'(src_ptr);
        s_tlast_i[ch]          = (src_ptr == ulen - 1);
    endtask

    // One IN token; src_ptr carries the user packet position across tokens.
    task automatic run_in(input int ch, input int ulen, input int exp_beats, input logic [7:0] base);
        int   beat;
        logic exp_last;
        logic done;
        beat = 0;
        done = 1'b0;
        while (!done && beat < 40) begin
            drive_src(ch, ulen, base);
            c_tready_i = 1'b1;
            #1;
            exp_last = (src_ptr == ulen - 1) || (beat == MAXP - 1);
            check("in_valid", 32'(c_tvalid_o), 1);
            check("in_data", 32'(c_tdata_o), 32'(8'(base + 8'(src_ptr))));
            check("in_last", 32'(c_tlast_o), 32'(exp_last));
            check("in_sready", 32'(s_tready_o), 1 << ch);
            @(negedge clock);
            src_ptr++;
            beat++;
            if (exp_last) done = 1'b1;
        end
        clear_src();
        check("in_beats", beat, exp_beats);
        check("in_idle", 32'(ep_active_o), 0);
    endtask

    task automatic run_out(input int ch, input int len, input int err_at);
        logic err_flag;
        logic exp_err;
        err_flag = 1'b0;
        for (int i = 0; i < len; i++) begin
            c_tvalid_i  = 1'b1;
            c_tdata_i   = 8'(8'hA0 + i);
            c_tlast_i   = (i == len - 1);
            blk_error_i = (i == err_at);
            m_tready_i  = '0;
            m_tready_i[ch] = 1'b1;
            #1;
            exp_err = (err_flag || (i == err_at)) && (i == len - 1);
            check("out_mvalid", 32'(m_tvalid_o), 1 << ch);
            check("out_data", 32'(m_tdata_o[ch*8 +: 8]), (8'hA0 + i) & 255);
            check("out_last", 32'(m_tlast_o), (i == len - 1) ? (1 << ch) : 0);
            check("out_terr", 32'(m_terr_o), exp_err ? (1 << ch) : 0);
            check("out_ctready", 32'(c_tready_o), 1);
            @(negedge clock);
            if (i == err_at) err_flag = 1'b1;
        end
        c_tvalid_i  = 1'b0;
        c_tlast_i   = 1'b0;
        blk_error_i = 1'b0;
        m_tready_i  = '0;
        check("out_idle", 32'(ep_active_o), 0);
    endtask

    initial begin
        int xferred;
        int k;
        areset_n = 1'b0; usb_reset_i = 1'b0;
        blk_endpt_i = 4'd0; blk_dir_i = 1'b0; blk_start_i = 1'b0;
        blk_cycle_i = 1'b0; blk_error_i = 1'b0;
        c_tvalid_i = 1'b0; c_tlast_i = 1'b0; c_tdata_i = 8'd0;
        ep_in_ready_i = '0; ep_out_ready_i = '0; m_tready_i = '0;
        clear_src();
        src_ptr = 0;
        repeat (2) @(negedge clock);

        // reset state
        check("rst_cvalid", 32'(c_tvalid_o), 0);
        check("rst_ctready", 32'(c_tready_o), 0);
        check("rst_in_rdy", 32'(blk_in_ready_o), 0);
        check("rst_out_rdy", 32'(blk_out_ready_o), 0);
        check("rst_blk_err", 32'(blk_error_o), 0);
        check("rst_active", 32'(ep_active_o), 0);
        check("rst_abort", 32'(ep_abort_o), 0);
        check("rst_mvalid", 32'(m_tvalid_o), 0);
        areset_n = 1'b1;
        @(negedge clock);

        // ready reporting, one cycle of lag
        blk_endpt_i = 4'd2; ep_in_ready_i = 2'b10; ep_out_ready_i = 2'b01;
        #1;
        check("in_rdy_lag", 32'(blk_in_ready_o), 0);
        @(negedge clock);
        check("in_rdy_ep2", 32'(blk_in_ready_o), 1);
        check("out_rdy_ep2", 32'(blk_out_ready_o), 0);
        blk_endpt_i = 4'd1;
        #1;
        check("in_rdy_hold", 32'(blk_in_ready_o), 1);
        @(negedge clock);
        check("in_rdy_ep1", 32'(blk_in_ready_o), 0);
        check("out_rdy_ep1", 32'(blk_out_ready_o), 1);
        ep_in_ready_i = 2'b11; ep_out_ready_i = 2'b11;
        blk_endpt_i = 4'd3;
        @(negedge clock);
        check("in_rdy_ep3", 32'(blk_in_ready_o), 0);
        check("out_rdy_ep3", 32'(blk_out_ready_o), 0);
        blk_endpt_i = 4'd0;
        @(negedge clock);
        check("out_rdy_ep0", 32'(blk_out_ready_o), 0);

        // start to an unmapped endpoint
        blk_endpt_i = 4'd5; blk_dir_i = 1'b1; blk_start_i = 1'b1; blk_cycle_i = 1'b1;
        #1;
        check("err_lag", 32'(blk_error_o), 0);
        @(negedge clock);
        blk_start_i = 1'b0;
        check("err_pulse", 32'(blk_error_o), 1);
        check("err_active", 32'(ep_active_o), 0);
        @(negedge clock);
        check("err_clear", 32'(blk_error_o), 0);
        check("err_active2", 32'(ep_active_o), 0);

        // 16-byte packet on endpoint 2 splits into two 8-byte tokens
        src_ptr = 0;
        start_xfer(4'd2, 1'b1, 1);
        run_in(1, 16, 8, 8'h00);
        start_xfer(4'd2, 1'b1, 1);
        run_in(1, 16, 8, 8'h00);

        // 12-byte packet on endpoint 1: 8 with forced tlast, then 4
        src_ptr = 0;
        start_xfer(4'd1, 1'b1, 0);
        run_in(0, 12, 8, 8'h40);
        start_xfer(4'd1, 1'b1, 0);
        run_in(0, 12, 4, 8'h40);

        // OUT with error at byte 3 of 10, then a clean packet
        start_xfer(4'd1, 1'b0, 0);
        run_out(0, 10, 2);
        start_xfer(4'd1, 1'b0, 0);
        run_out(0, 5, -1);

        // blk_cycle_i drops at byte 5 while c_tready_i toggles
        src_ptr = 0;
        start_xfer(4'd2, 1'b1, 1);
        xferred = 0;
        k = 0;
        while (xferred < 4 && k < 20) begin
            drive_src(1, 8, 8'h80);
            c_tready_i = (k % 2 == 0);
            #1;
            check("ab_valid", 32'(c_tvalid_o), 1);
            check("ab_data", 32'(c_tdata_o), 32'(8'h80 + 8'(src_ptr)));
            @(negedge clock);
            if (k % 2 == 0) begin
                src_ptr++;
                xferred++;
            end
            k++;
        end
        check("ab_xferred", xferred, 4);
        drive_src(1, 8, 8'h80);
        c_tready_i  = 1'b1;
        blk_cycle_i = 1'b0;
        #1;
        check("ab_cvalid", 32'(c_tvalid_o), 0);
        check("ab_sready", 32'(s_tready_o), 0);
        check("ab_pulse", 32'(ep_abort_o), 2);
        @(negedge clock);
        check("ab_idle", 32'(ep_active_o), 0);
        check("ab_pulse_end", 32'(ep_abort_o), 0);
        clear_src();
        blk_cycle_i = 1'b1;

        // usb_reset_i in IDLE ignores a start
        usb_reset_i = 1'b1; blk_endpt_i = 4'd1; blk_dir_i = 1'b1; blk_start_i = 1'b1;
        @(negedge clock);
        blk_start_i = 1'b0;
        check("usbrst_active", 32'(ep_active_o), 0);
        check("usbrst_err", 32'(blk_error_o), 0);
        usb_reset_i = 1'b0;

        // async reset in the middle of an IN transfer
        src_ptr = 0;
        start_xfer(4'd1, 1'b1, 0);
        drive_src(0, 6, 8'h10);
        c_tready_i = 1'b1;
        @(negedge clock);
        src_ptr++;
        drive_src(0, 6, 8'h10);
        areset_n = 1'b0;
        #1;
        check("mid_rst_cvalid", 32'(c_tvalid_o), 0);
        check("mid_rst_sready", 32'(s_tready_o), 0);
        check("mid_rst_active", 32'(ep_active_o), 0);
        check("mid_rst_clast", 32'(c_tlast_o), 0);
        check("mid_rst_in_rdy", 32'(blk_in_ready_o), 0);
        @(negedge clock);
        areset_n = 1'b1;
        clear_src();
        @(negedge clock);
        start_xfer(4'd2, 1'b0, 1);
        run_out(1, 3, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/usb_bulk_router.md
# usb_bulk_router

Parametrised N-channel bulk-endpoint router between the USB protocol core's single bulk data-path and NUM_EPS independent AXI4-Stream endpoint channels. It decodes the token endpoint number, reports the selected channel's readiness back to the core, and steers IN and OUT packet streams to the addressed channel. It adds packet-size enforcement, OUT error tagging and abort signalling, none of which the single-channel top level provides. It sits between the protocol core and the user endpoint FIFOs inside the ULPI/AXIS top level.

## Interface
Parameters:
- NUM_EPS, 2: number of bulk channels (1..15).
- EP_FIRST, 1: USB endpoint number of channel 0; channel k serves endpoint EP_FIRST+k.
- MAX_PACKET, 512: maximum IN packet length in bytes (power of two, 8..1024).

Ports:
- clock  in  1: USB/ULPI clock domain.
- areset_n  in  1: asynchronous, active-low reset.
- usb_reset_i  in  1: USB bus reset; aborts any transfer.
- blk_endpt_i  in  4: token endpoint number from core.
- blk_dir_i  in  1: 1 = IN (device->host), 0 = OUT.
- blk_start_i  in  1: one-cycle pulse, transfer begins.
- blk_cycle_i  in  1: high for the duration of the transfer.
- blk_error_i  in  1: core-detected error (CRC/PID) during OUT.
- blk_in_ready_o  out  1: addressed channel has an IN packet.
- blk_out_ready_o  out  1: addressed channel can accept MAX_PACKET bytes.
- blk_error_o  out  1: one-cycle pulse, start to an unmapped endpoint.
- c_tvalid_o / c_tready_i / c_tlast_o / c_tdata_o[7:0]: IN stream to core.
- c_tvalid_i / c_tready_o / c_tlast_i / c_tdata_i[7:0]: OUT stream from core.
- ep_in_ready_i  in  NUM_EPS: per-channel IN-packet-available.
- ep_out_ready_i  in  NUM_EPS: per-channel OUT-space-available.
- s_tvalid_i, s_tlast_i  in  NUM_EPS; s_tready_o  out  NUM_EPS; s_tdata_i  in  8*NUM_EPS: IN channels.
- m_tvalid_o, m_tlast_o, m_terr_o  out  NUM_EPS; m_tready_i  in  NUM_EPS; m_tdata_o  out  8*NUM_EPS: OUT channels.
- ep_active_o  out  NUM_EPS: one-hot, channel selected.
- ep_abort_o  out  NUM_EPS: one-cycle abort pulse per channel.

## Operation
- Decode: idx = blk_endpt_i − EP_FIRST (4-bit unsigned); hit = (blk_endpt_i ≥ EP_FIRST) && (idx < NUM_EPS).
- blk_in_ready_o / blk_out_ready_o = hit & ep_in_ready_i[idx] / ep_out_ready_i[idx], registered; 0 on a miss.
- FSM states: IDLE, IN_XFER, OUT_XFER.
  - IDLE + blk_start_i with a miss: pulse blk_error_o and stay in IDLE.
  - IDLE + blk_start_i with a hit: latch sel=idx and go to IN_XFER (blk_dir_i=1) or OUT_XFER (blk_dir_i=0). Clear count (10-bit) and err_seen.
- IN_XFER:
  - c_tvalid_o = s_tvalid_i[sel]; c_tdata_o = s_tdata_i[sel]; s_tready_o[sel] = c_tready_i; all other s_tready_o stay 0.
  - c_tlast_o = s_tlast_i[sel] | (count == MAX_PACKET−1).
  - count increments on each handshake and clears on a c_tlast_o handshake.
  - The FSM returns to IDLE on a handshake with c_tlast_o high. An oversize user packet therefore splits; the remainder goes out on the next IN token.
- OUT_XFER:
  - m_tvalid_o[sel] = c_tvalid_i; c_tready_o = m_tready_i[sel]; data and tlast pass through.
  - err_seen is set by blk_error_i.
  - m_terr_o[sel] = (err_seen | blk_error_i) & c_tlast_i, qualified with m_tvalid_o[sel].
  - The FSM returns to IDLE on the tlast handshake.
- Abort: blk_cycle_i low or usb_reset_i high while in an XFER state causes:
  - ep_abort_o[sel] pulses for one cycle;
  - FSM goes to IDLE next cycle;
  - no beat is emitted that cycle: c_tvalid_o, c_tready_o, s_tready_o and m_tvalid_o are forced to 0 in the abort cycle.
- usb_reset_i in IDLE ignores blk_start_i.

## Timing
- Reset: FSM IDLE; sel=0; count=0; err_seen=0. Every output is 0.
- Ready outputs lag blk_endpt_i and ep_*_ready_i by 1 cycle.
- blk_error_o pulses 1 cycle after blk_start_i.
- The XFER state and ep_active_o are valid from the cycle after blk_start_i. The data path is combinational (zero latency) from then on.
- A tlast handshake in cycle t puts the FSM in IDLE at t+1. blk_start_i at t+1 is accepted.
- Simultaneous tlast handshake and abort: abort wins. No handshake occurs and ep_abort_o pulses.
- Counter wrap: after MAX_PACKET beats without s_tlast_i, forced tlast and count returns to 0.

## Test plan
- Reset mid-IN_XFER (areset_n low 1 cycle): all outputs 0, FSM in IDLE; next blk_start_i is accepted normally.
- NUM_EPS=2, EP_FIRST=1, endpoint 2 IN, ep_in_ready_i=2'b10: blk_in_ready_o=1 one cycle later. A 16-byte packet 0x00..0x0F reaches the core with tlast on 0x0F; s_tready_o[0] stays 0.
- Endpoint 5 start: blk_error_o one-cycle pulse, FSM stays IDLE, ep_active_o=0.
- MAX_PACKET=8, user packet of 12 bytes: first IN transfer carries 8 bytes with forced tlast. Second IN token carries 4 bytes ending on the user's tlast.
- OUT to endpoint 1 with blk_error_i pulsed at byte 3 of 10: m_terr_o[0]=1 only on the byte-10 tlast beat. A following clean OUT packet has m_terr_o=0.
- blk_cycle_i drops at byte 5 of an IN packet while c_tready_i is toggling: ep_abort_o[sel] pulses once, no beat is transferred in the abort cycle, FSM is IDLE next cycle.
